// File: rtl/irq_sched_pkg.sv
// Shared types and helpers for the irq_sched27 interrupt front-end.
package irq_sched_pkg;

    localparam int NCH = 9;

    typedef enum logic [1:0] {
        GRP_NONE = 2'b00,
        GRP_A    = 2'b01,
        GRP_B    = 2'b10,
        GRP_C    = 2'b11
    } irq_grp_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESENT = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

    // One-hot mask selecting channel c, used to clear a single pending bit.
    function automatic logic [NCH-1:0] chan_onehot(input logic [3:0] c);
        chan_onehot = {{(NCH-1){1'b0}}, 1'b1} << c;
    endfunction

endpackage

// File: rtl/irq_prio9.sv
// Combinational 9-bit priority encoder: highest set bit index wins.
module irq_prio9
    import irq_sched_pkg::*;
(
    input  logic [NCH-1:0] vec,
    output logic           hit,
    output logic [3:0]     idx
);

    // Scan upward so the highest set index is the last one kept.
    always_comb begin
        hit = |vec;
        idx = 4'd0;
        for (int i = 0; i < NCH; i++) begin
            idx = vec[i] ? 4'(i) : idx;
        end
    end

endmodule

// File: rtl/irq_sched27.sv
// irq_sched27: edge capture, enable mask, fixed-priority arbitration and a
// present/service handshake for 27 interrupt channels (groups A, B, C).
// Optional build macro IRQ_AGING_EN: pending C is promoted above A and B
// after AGE_LIMIT consecutive A/B acks while C waits.
module irq_sched27
    import irq_sched_pkg::*;
#(
    parameter logic [8:0] EN_RESET  = 9'h1FF,
    parameter int         AGE_LIMIT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [8:0] req_a,
    input  logic [8:0] req_b,
    input  logic [8:0] req_c,
    input  logic       cfg_we,
    input  logic [8:0] cfg_en,
    output logic       irq_valid,
    output logic [1:0] irq_grp,
    output logic [3:0] irq_chan,
    input  logic       irq_ack,
    input  logic       eoi,
    output logic       busy,
    output logic       pend_any
);

    localparam logic [1:0] ST_IDLE    = IDLE;
    localparam logic [1:0] ST_PRESENT = PRESENT;
    localparam logic [1:0] ST_SERVICE = SERVICE;

    logic [NCH-1:0] req_a_q, req_b_q, req_c_q;
    logic [NCH-1:0] pend_a_q, pend_b_q, pend_c_q;
    logic [NCH-1:0] pend_a_d, pend_b_d, pend_c_d;
    logic [NCH-1:0] en_q, en_d;
    logic [1:0]     state_q, state_d;
    logic [1:0]     grp_q, grp_d;
    logic [3:0]     chan_q, chan_d;
    logic           valid_q, valid_d, busy_q, busy_d, pend_any_q, pend_any_d;

    logic [NCH-1:0] clr_a_s, clr_b_s, clr_c_s;
    logic           ack_s;
    logic           hit_a_s, hit_b_s, hit_c_s;
    logic [3:0]     idx_a_s, idx_b_s, idx_c_s;
    logic [1:0]     win_grp_s;
    logic [3:0]     win_chan_s;
    logic           age_sat_s;

    assign ack_s = (state_q == ST_PRESENT) && irq_ack;

    irq_prio9 u_prio_a (.vec(pend_a_q & en_q), .hit(hit_a_s), .idx(idx_a_s));
    irq_prio9 u_prio_b (.vec(pend_b_q & en_q), .hit(hit_b_s), .idx(idx_b_s));
    irq_prio9 u_prio_c (.vec(pend_c_q & en_q), .hit(hit_c_s), .idx(idx_c_s));

`ifdef IRQ_AGING_EN
    localparam int AGE_W = $clog2(AGE_LIMIT + 1);
    logic [AGE_W-1:0] age_q, age_d;

    assign age_sat_s = (age_q == AGE_W'(AGE_LIMIT));

    // Count A/B acks that bypass a waiting C; any C ack restarts the count.
    always_comb begin
        age_d = age_q;
        if (ack_s) begin
            if (grp_q == GRP_C) begin
                age_d = {AGE_W{1'b0}};
            end else if (hit_c_s && !age_sat_s) begin
                age_d = age_q + AGE_W'(1);
            end else begin
                age_d = age_q;
            end
        end else begin
            age_d = age_q;
        end
    end

    // Age counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            age_q <= {AGE_W{1'b0}};
        end else begin
            age_q <= age_d;
        end
    end
`else
    localparam int unused_age_limit = AGE_LIMIT;
    assign age_sat_s = 1'b0;
`endif

    // Winner select: an aged C first, then A > B > C.
    always_comb begin
        win_grp_s  = GRP_NONE;
        win_chan_s = 4'd0;
        if (age_sat_s && hit_c_s) begin
            win_grp_s  = GRP_C;
            win_chan_s = idx_c_s;
        end else if (hit_a_s) begin
            win_grp_s  = GRP_A;
            win_chan_s = idx_a_s;
        end else if (hit_b_s) begin
            win_grp_s  = GRP_B;
            win_chan_s = idx_b_s;
        end else if (hit_c_s) begin
            win_grp_s  = GRP_C;
            win_chan_s = idx_c_s;
        end else begin
            win_grp_s  = GRP_NONE;
            win_chan_s = 4'd0;
        end
    end

    // Pending update: clear the acked winner, new enabled edges win over the clear.
    always_comb begin
        clr_a_s = {NCH{1'b0}};
        clr_b_s = {NCH{1'b0}};
        clr_c_s = {NCH{1'b0}};
        if (ack_s) begin
            case (grp_q)
                GRP_A:   clr_a_s = chan_onehot(chan_q);
                GRP_B:   clr_b_s = chan_onehot(chan_q);
                GRP_C:   clr_c_s = chan_onehot(chan_q);
                default: clr_a_s = {NCH{1'b0}};
            endcase
        end else begin
            clr_a_s = {NCH{1'b0}};
        end
        pend_a_d   = (pend_a_q & ~clr_a_s) | (req_a & ~req_a_q & en_q);
        pend_b_d   = (pend_b_q & ~clr_b_s) | (req_b & ~req_b_q & en_q);
        pend_c_d   = (pend_c_q & ~clr_c_s) | (req_c & ~req_c_q & en_q);
        en_d       = cfg_we ? cfg_en : en_q;
        pend_any_d = |((pend_a_q | pend_b_q | pend_c_q) & en_q);
    end

    // Handshake FSM: IDLE picks a winner, PRESENT waits for ack, SERVICE for eoi.
    always_comb begin
        state_d = state_q;
        grp_d   = grp_q;
        chan_d  = chan_q;
        case (state_q)
            ST_IDLE: begin
                if (win_grp_s != GRP_NONE) begin
                    state_d = ST_PRESENT;
                    grp_d   = win_grp_s;
                    chan_d  = win_chan_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PRESENT: begin
                if (irq_ack) begin
                    state_d = ST_SERVICE;
                end else begin
                    state_d = ST_PRESENT;
                end
            end
            ST_SERVICE: begin
                if (eoi) begin
                    state_d = ST_IDLE;
                    grp_d   = GRP_NONE;
                end else begin
                    state_d = ST_SERVICE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                grp_d   = GRP_NONE;
            end
        endcase
        valid_d = (state_d == ST_PRESENT);
        busy_d  = (state_d == ST_SERVICE);
    end

    // State, capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_a_q    <= {NCH{1'b0}};
            req_b_q    <= {NCH{1'b0}};
            req_c_q    <= {NCH{1'b0}};
            pend_a_q   <= {NCH{1'b0}};
            pend_b_q   <= {NCH{1'b0}};
            pend_c_q   <= {NCH{1'b0}};
            en_q       <= EN_RESET;
            state_q    <= ST_IDLE;
            grp_q      <= GRP_NONE;
            chan_q     <= 4'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            pend_any_q <= 1'b0;
        end else begin
            req_a_q    <= req_a;
            req_b_q    <= req_b;
            req_c_q    <= req_c;
            pend_a_q   <= pend_a_d;
            pend_b_q   <= pend_b_d;
            pend_c_q   <= pend_c_d;
            en_q       <= en_d;
            state_q    <= state_d;
            grp_q      <= grp_d;
            chan_q     <= chan_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            pend_any_q <= pend_any_d;
        end
    end

    assign irq_valid = valid_q;
    assign irq_grp   = grp_q;
    assign irq_chan  = chan_q;
    assign busy      = busy_q;
    assign pend_any  = pend_any_q;

endmodule

// File: tb/tb_irq_sched27.sv
// Directed self-checking bench for irq_sched27 (AGE_LIMIT = 2).
module tb_irq_sched27;

    logic       clk, rst;
    logic [8:0] req_a, req_b, req_c, cfg_en;
    logic       cfg_we, irq_ack, eoi;
    logic       irq_valid, busy, pend_any;
    logic [1:0] irq_grp;
    logic [3:0] irq_chan;

    int total = 0;
    int bad   = 0;

    logic [1:0] g6 [3];
    logic [3:0] c6 [3];

    irq_sched27 #(.EN_RESET(9'h1FF), .AGE_LIMIT(2)) dut (
        .clk(clk), .rst(rst), .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .cfg_we(cfg_we), .cfg_en(cfg_en), .irq_valid(irq_valid),
        .irq_grp(irq_grp), .irq_chan(irq_chan), .irq_ack(irq_ack),
        .eoi(eoi), .busy(busy), .pend_any(pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] id_now();
        return {2'b00, irq_valid, irq_grp, irq_chan};
    endfunction

    function automatic logic [8:0] id_exp(input logic [1:0] g, input logic [3:0] c);
        return {2'b00, 1'b1, g, c};
    endfunction

    task automatic serve();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_a = 9'h000; req_b = 9'h000; req_c = 9'h000;
        cfg_we = 1'b0; cfg_en = 9'h000; irq_ack = 1'b0; eoi = 1'b0;
        tick(); tick();
        chk("reset_id", id_now(), 9'h000);
        chk("reset_busy_pend", {7'd0, busy, pend_any}, 9'h000);
        rst = 1'b0;

        // Single A3 pulse.
        req_a = 9'h008; tick(); req_a = 9'h000;
        chk("a3_not_yet", {8'd0, irq_valid}, 9'h000);
        tick();
        chk("a3_present", id_now(), id_exp(2'b01, 4'd3));
        chk("a3_pend_any", {8'd0, pend_any}, 9'h001);
        irq_ack = 1'b1; tick(); irq_ack = 1'b0;
        chk("a3_ack_state", {6'd0, irq_valid, busy, 1'b0}, 9'h002);
        chk("a3_ack_id", {3'd0, irq_grp, irq_chan}, 9'h013);
        tick();
        chk("a3_cleared", {8'd0, pend_any}, 9'h000);
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("a3_eoi", {6'd0, irq_valid, busy, 1'b0}, 9'h000);
        chk("a3_eoi_grp", {7'd0, irq_grp}, 9'h000);

        // Simultaneous A0, B8, C8: serviced A0, B8, C8 with a bubble each.
        req_a = 9'h001; req_b = 9'h100; req_c = 9'h100; tick();
        req_a = 9'h000; req_b = 9'h000; req_c = 9'h000; tick();
        chk("ord_a0", id_now(), id_exp(2'b01, 4'd0));
        serve();
        chk("ord_bubble", {6'd0, irq_valid, irq_grp}, 9'h000);
        tick();
        chk("ord_b8", id_now(), id_exp(2'b10, 4'd8));
        serve(); tick();
        chk("ord_c8", id_now(), id_exp(2'b11, 4'd8));
        serve(); tick();
        chk("ord_empty", {7'd0, irq_valid, pend_any}, 9'h000);

        // Disabled channel drops its edge permanently.
        cfg_we = 1'b1; cfg_en = 9'h1EF; tick(); cfg_we = 1'b0;
        req_a = 9'h010; tick(); req_a = 9'h000; tick(); tick();
        chk("mask_drop", {7'd0, irq_valid, pend_any}, 9'h000);
        cfg_we = 1'b1; cfg_en = 9'h1FF; tick(); cfg_we = 1'b0; tick(); tick();
        chk("mask_reenable", {7'd0, irq_valid, pend_any}, 9'h000);

        // B5 presented, enable cleared before ack, stray eoi ignored.
        req_b = 9'h020; tick(); req_b = 9'h000; tick();
        chk("b5_present", id_now(), id_exp(2'b10, 4'd5));
        cfg_we = 1'b1; cfg_en = 9'h1DF; tick(); cfg_we = 1'b0;
        eoi = 1'b1; tick(); eoi = 1'b0;
        chk("b5_hold_masked", id_now(), id_exp(2'b10, 4'd5));
        cfg_we = 1'b1; cfg_en = 9'h1FF; tick(); cfg_we = 1'b0;
        irq_ack = 1'b1; req_b = 9'h020; tick();
        irq_ack = 1'b0; req_b = 9'h000; tick();
        chk("b5_set_wins", {7'd0, busy, pend_any}, 9'h003);
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        chk("b5_again", id_now(), id_exp(2'b10, 4'd5));
        serve();
        chk("b5_done", {6'd0, irq_valid, irq_grp}, 9'h000);
        chk("b5_done_pend", {8'd0, pend_any}, 9'h000);

        // Request held high across reset gives exactly one event.
        cfg_we = 1'b1; cfg_en = 9'h000; tick(); cfg_we = 1'b0;
        req_a = 9'h004; tick();
        rst = 1'b1; tick(); tick();
        chk("rst_mid", {5'd0, irq_valid, busy, pend_any, 1'b0}, 9'h000);
        rst = 1'b0; tick(); tick();
        chk("rst_a2", id_now(), id_exp(2'b01, 4'd2));
        serve(); tick(); tick(); tick();
        chk("rst_no_second", {7'd0, irq_valid, pend_any}, 9'h000);
        req_a = 9'h000; tick();

        // C1 waiting behind continuous A/B traffic.
`ifdef IRQ_AGING_EN
        g6[0] = 2'b11; c6[0] = 4'd1;
        g6[1] = 2'b01; c6[1] = 4'd5;
        g6[2] = 2'b10; c6[2] = 4'd6;
`else
        g6[0] = 2'b01; c6[0] = 4'd5;
        g6[1] = 2'b10; c6[1] = 4'd6;
        g6[2] = 2'b11; c6[2] = 4'd1;
`endif
        req_c = 9'h002; req_a = 9'h080; tick();
        req_c = 9'h000; req_a = 9'h000; tick();
        chk("age_a7", id_now(), id_exp(2'b01, 4'd7));
        irq_ack = 1'b1; req_a = 9'h040; req_b = 9'h040; tick();
        irq_ack = 1'b0; req_a = 9'h000; req_b = 9'h000;
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        chk("age_a6", id_now(), id_exp(2'b01, 4'd6));
        irq_ack = 1'b1; req_a = 9'h020; tick();
        irq_ack = 1'b0; req_a = 9'h000;
        eoi = 1'b1; tick(); eoi = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("age_seq%0d", i), id_now(), id_exp(g6[i], c6[i]));
            serve();
            tick();
        end
        chk("age_empty", {7'd0, irq_valid, pend_any}, 9'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
